crc_frame_ctrl: RTL and testbench
=================================

Name: crc_frame_ctrl

Overview:
Sequencer that drives the serial CRC engine from a parallel message interface. On a START request it latches a DATA_BYTES-wide message and issues a one-cycle clear to the engine. It then shifts the message into the engine LSB-first under ACTIVE, waits for the engine's Valid, and deserialises the CRC_BITS-bit serial CRC into a parallel result with a DONE pulse. It sits between the bus/host logic and the CRC engine, and is the only block that drives the engine's control inputs.

Parameters:
CRC_BITS, 8, CRC width; must match the engine's crc_bits.
DATA_BYTES, 1, message length in bytes (legal values 1..3); must match the engine's data_bytes.
TIMEOUT, 64, maximum cycles to wait for ENG_VALID after ACTIVE drops.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST  in  1  asynchronous, active-low reset.
START  in  1  frame request; sampled only in IDLE.
FRAME_DATA  in  DATA_BYTES*8  message; latched on the accepted START.
BUSY  out  1  high in every state except IDLE.
ENG_RST  out  1  active-low registered clear to the engine's RST.
ENG_ACTIVE  out  1  to the engine's ACTIVE.
ENG_DATA  out  1  to the engine's DATA (serial message, LSB first).
ENG_VALID  in  1  from the engine's Valid.
ENG_CRC  in  1  from the engine's CRC (serial result, bit 0 first).
CRC_OUT  out  CRC_BITS  last good CRC result; held until the next good frame.
DONE  out  1  one-cycle pulse when a frame completes, good or errored.
ERR  out  1  one-cycle pulse coincident with DONE on timeout or Valid dropout.

Behaviour:
- Reset values (RST low, asynchronous): state IDLE, BUSY=0, ENG_RST=0 (engine held in clear), ENG_ACTIVE=0, ENG_DATA=0, CRC_OUT=0, DONE=0, ERR=0, all counters 0.
- All outputs are registered.
- IDLE: ENG_RST=1. If START=1, latch FRAME_DATA into msg_sr and go to CLEAR.
- START while BUSY is ignored. No queueing.
- CLEAR: exactly 1 cycle. ENG_RST=0, then go to SHIFT.
- SHIFT: exactly DATA_BYTES*8 cycles.
  - ENG_ACTIVE=1 and ENG_DATA=msg_sr[0]; msg_sr shifts right each cycle.
  - bit_cnt counts 0..DATA_BYTES*8-1.
  - On the last bit go to WAIT_VALID, with ENG_ACTIVE=0 from the next cycle.
- WAIT_VALID: ENG_ACTIVE=0 and tmo_cnt increments each cycle.
  - First rising edge with ENG_VALID=1: sample ENG_CRC as result bit 0, set cap_cnt=1, go to CAPTURE.
  - If tmo_cnt reaches TIMEOUT-1 with no Valid: go to DONE_ST with err flag set.
- CAPTURE: each rising edge with ENG_VALID=1 samples ENG_CRC into crc_sr[cap_cnt], then cap_cnt increments.
  - When cap_cnt reaches CRC_BITS, go to DONE_ST.
  - ENG_VALID=0 before all CRC_BITS bits are captured: go to DONE_ST with err flag set.
- DONE_ST: 1 cycle.
  - DONE=1 and ERR=err flag.
  - If no error, CRC_OUT<=crc_sr in the same edge. On error, CRC_OUT is unchanged.
  - Then go to IDLE. A START in that IDLE cycle is accepted, giving back-to-back frames.
- Latency from START to DONE with an engine whose Valid follows ACTIVE-low by V cycles: 1 + 1 + DATA_BYTES*8 + V + CRC_BITS cycles.
- Counter widths: bit_cnt is clog2(DATA_BYTES*8+1), cap_cnt is clog2(CRC_BITS+1), tmo_cnt is clog2(TIMEOUT+1). Counters saturate and never wrap.
- RST asserted mid-frame: immediate return to IDLE with reset values. The partial crc_sr is discarded and CRC_OUT is cleared to 0.
- ENG_VALID high while in IDLE, CLEAR or SHIFT is ignored.

Decomposition:
- crc_ctrl_pkg holds:
  - state encoding: IDLE, CLEAR, SHIFT, WAIT_VALID, CAPTURE, DONE_ST;
  - clog2 function and counter-width constants;
  - default CRC_BITS, DATA_BYTES, TIMEOUT.
- One natural sub-module, crc_piso, owns the msg_sr load/shift and bit_cnt. It exposes the bit, a last-bit flag and a load/shift enable.
- Capture and timeout logic stay in crc_frame_ctrl.

Test Plan:
- Engine with poly 0xC4, CRC_BITS=8, DATA_BYTES=1. FRAME_DATA=0x93 with a START pulse -> ENG_DATA sequence 1,1,0,0,1,0,0,1; DONE=1, ERR=0, CRC_OUT=0x78.
- FRAME_DATA=0x5D -> CRC_OUT=0x58, DONE pulses exactly once.
- Two frames (0x93, then 0x5D), with START held high through DONE -> second frame starts in the IDLE cycle after DONE_ST; ENG_RST low exactly one cycle per frame; results 0x78 then 0x58.
- Stub engine holding ENG_VALID=0 -> DONE=ERR=1 exactly TIMEOUT cycles after WAIT_VALID entry; CRC_OUT keeps the prior value 0x58.
- Stub engine dropping Valid after 3 bits -> DONE=ERR=1 one cycle later; CRC_OUT unchanged.
- RST pulsed low mid-SHIFT (bit 4) -> all outputs return to reset values asynchronously. A new START 0x93 after release -> CRC_OUT=0x78.

Source files
------------

// File: rtl/crc_ctrl_pkg.sv
// Shared types and sizing helpers for the CRC frame sequencer.
// The state encoding, counter widths and default geometry all live here.
package crc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    SHIFT      = 3'd2,
    WAIT_VALID = 3'd3,
    CAPTURE    = 3'd4,
    DONE_ST    = 3'd5
  } ctrl_state_t;

  localparam int DEF_CRC_BITS   = 8;
  localparam int DEF_DATA_BYTES = 1;
  localparam int DEF_TIMEOUT    = 64;

  // Smallest width able to hold values 0..value-1 (callers pass max+1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_BIT_CNT_W = clog2(DEF_DATA_BYTES * 8 + 1);
  localparam int DEF_CAP_CNT_W = clog2(DEF_CRC_BITS + 1);
  localparam int DEF_TMO_CNT_W = clog2(DEF_TIMEOUT + 1);

endpackage

// File: rtl/crc_frame_ctrl_piso.sv
// Parallel-in serial-out message register feeding the CRC engine LSB first.
// bit_cnt counts bits handed out; last is high while the final bit is on the line.
module crc_piso
  import crc_ctrl_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    shift,
  input  logic [DATA_BYTES*8-1:0] din,
  output logic                    bit_out,
  output logic                    last
);

  localparam int MSG_BITS = DATA_BYTES * 8;
  localparam int CNT_W    = clog2(MSG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSG_BITS);

  logic [MSG_BITS-1:0] msg_sr;
  logic [MSG_BITS-1:0] shifted;
  logic [CNT_W-1:0]    bit_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < MSG_BITS; gi++) begin : g_shift
      if (gi == MSG_BITS - 1) begin : g_msb
        assign shifted[gi] = 1'b0;
      end else begin : g_lower
        assign shifted[gi] = msg_sr[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_sr  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      msg_sr  <= din;
      bit_cnt <= '0;
    end else if (shift) begin
      msg_sr  <= shifted;
      if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign bit_out = msg_sr[0];
  assign last    = (bit_cnt == CNT_FULL);

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the serial CRC engine: clear, shift message, wait for
// Valid, deserialise the CRC and report DONE/ERR. All outputs are registered.
module crc_frame_ctrl
  import crc_ctrl_pkg::*;
#(
  parameter int CRC_BITS   = DEF_CRC_BITS,
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,          // active low, asynchronous
  input  logic                    start,
  input  logic [DATA_BYTES*8-1:0] frame_data,
  output logic                    busy,
  output logic                    eng_rst,      // active low clear to the engine
  output logic                    eng_active,
  output logic                    eng_data,
  input  logic                    eng_valid,
  input  logic                    eng_crc,
  output logic [CRC_BITS-1:0]     crc_out,
  output logic                    done,
  output logic                    err
);

  localparam int CAP_W = clog2(CRC_BITS + 1);
  localparam int TMO_W = clog2(TIMEOUT + 1);
  localparam logic [CAP_W-1:0] CAP_FULL = CAP_W'(CRC_BITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  ctrl_state_t         state, state_next;
  logic [CRC_BITS-1:0] crc_sr, crc_sr_next;
  logic [CAP_W-1:0]    cap_cnt, cap_cnt_next;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_next;
  logic                err_flag, err_next;
  logic                piso_load, piso_shift, piso_bit, piso_last;

  crc_piso #(
    .DATA_BYTES(DATA_BYTES)
  ) u_piso (
    .clk    (clk),
    .rst    (rst),
    .load   (piso_load),
    .shift  (piso_shift),
    .din    (frame_data),
    .bit_out(piso_bit),
    .last   (piso_last)
  );

  // The bit leaving the shifter on an edge is the one driven on eng_data.
  assign piso_shift = (state_next == SHIFT);

  always_comb begin
    state_next   = state;
    crc_sr_next  = crc_sr;
    cap_cnt_next = cap_cnt;
    tmo_cnt_next = tmo_cnt;
    err_next     = err_flag;
    piso_load    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          piso_load  = 1'b1;
          state_next = CLEAR;
        end
      end

      CLEAR: begin
        crc_sr_next  = '0;
        cap_cnt_next = '0;
        tmo_cnt_next = '0;
        err_next     = 1'b0;
        state_next   = SHIFT;
      end

      SHIFT: begin
        if (piso_last) state_next = WAIT_VALID;
      end

      WAIT_VALID: begin
        if (eng_valid) begin
          crc_sr_next[0] = eng_crc;
          cap_cnt_next   = CAP_W'(1);
          state_next     = (CAP_W'(1) == CAP_FULL) ? DONE_ST : CAPTURE;
        end else if (tmo_cnt >= TMO_LAST) begin
          err_next   = 1'b1;
          state_next = DONE_ST;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      CAPTURE: begin
        if (eng_valid) begin
          for (int i = 0; i < CRC_BITS; i++) begin
            if (cap_cnt == CAP_W'(i)) crc_sr_next[i] = eng_crc;
          end
          cap_cnt_next = (cap_cnt == CAP_FULL) ? cap_cnt : cap_cnt + 1'b1;
          if (cap_cnt_next == CAP_FULL) state_next = DONE_ST;
        end else begin
          // Valid dropped mid-result: the partial CRC is useless.
          err_next   = 1'b1;
          state_next = DONE_ST;
        end
      end

      DONE_ST: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      crc_sr     <= '0;
      cap_cnt    <= '0;
      tmo_cnt    <= '0;
      err_flag   <= 1'b0;
      busy       <= 1'b0;
      eng_rst    <= 1'b0;
      eng_active <= 1'b0;
      eng_data   <= 1'b0;
      crc_out    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      crc_sr     <= crc_sr_next;
      cap_cnt    <= cap_cnt_next;
      tmo_cnt    <= tmo_cnt_next;
      err_flag   <= err_next;
      // Outputs are registered from the next state so they line up with it.
      busy       <= (state_next != IDLE);
      eng_rst    <= (state_next != CLEAR);
      eng_active <= (state_next == SHIFT);
      eng_data   <= (state_next == SHIFT) & piso_bit;
      done       <= (state_next == DONE_ST);
      err        <= (state_next == DONE_ST) & err_next;
      if ((state_next == DONE_ST) && !err_next) crc_out <= crc_sr_next;
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl with a reactive engine stand-in and a
// scoreboard of expected frame results popped on every DONE.
module tb_crc_frame_ctrl;

  localparam int CRC_BITS   = 8;
  localparam int DATA_BYTES = 1;
  localparam int TIMEOUT    = 16;
  localparam int ENG_LAG    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_data = 8'h00;
  logic       busy, eng_rst, eng_active, eng_data;
  logic       eng_valid = 1'b0;
  logic       eng_crc = 1'b0;
  logic [7:0] crc_out;
  logic       done, err;

  crc_frame_ctrl #(
    .CRC_BITS  (CRC_BITS),
    .DATA_BYTES(DATA_BYTES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_data(frame_data),
    .busy      (busy),
    .eng_rst   (eng_rst),
    .eng_active(eng_active),
    .eng_data  (eng_data),
    .eng_valid (eng_valid),
    .eng_crc   (eng_crc),
    .crc_out   (crc_out),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Known results of the poly 0xC4 engine for the messages used here.
  function automatic logic [7:0] known_crc(input logic [7:0] msg);
    case (msg)
      8'h93:   return 8'h78;
      8'h5D:   return 8'h58;
      default: return msg ^ 8'hA5;
    endcase
  endfunction

  // Engine stand-in. Mode 0: normal, 1: never raises Valid, 2: Valid for 3 bits.
  int         eng_mode = 0;
  logic [7:0] stub_msg = 8'h00;
  int         stub_bits = 0;
  int         stub_phase = 0;
  int         stub_dly = 0;
  int         stub_ptr = 0;
  logic [7:0] stub_crc;
  assign stub_crc = known_crc(stub_msg);

  always @(posedge clk) begin
    if (!eng_rst) begin
      stub_msg   <= 8'h00;
      stub_bits  <= 0;
      stub_phase <= 0;
      stub_dly   <= 0;
      stub_ptr   <= 0;
      eng_valid  <= 1'b0;
      eng_crc    <= 1'b0;
    end else begin
      case (stub_phase)
        0: begin
          if (eng_active) begin
            stub_msg  <= {eng_data, stub_msg[7:1]};
            stub_bits <= stub_bits + 1;
          end else if (stub_bits != 0) begin
            stub_phase <= 1;
            stub_dly   <= 0;
          end
        end
        1: begin
          if (stub_dly == ENG_LAG - 1) begin
            stub_phase <= 2;
            if (eng_mode != 1) begin
              eng_valid <= 1'b1;
              eng_crc   <= stub_crc[0];
              stub_ptr  <= 1;
            end
          end else begin
            stub_dly <= stub_dly + 1;
          end
        end
        2: begin
          if (eng_mode != 1) begin
            if (stub_ptr == CRC_BITS || (eng_mode == 2 && stub_ptr == 3)) begin
              eng_valid  <= 1'b0;
              eng_crc    <= 1'b0;
              stub_phase <= 3;
            end else begin
              eng_crc  <= stub_crc[stub_ptr];
              stub_ptr <= stub_ptr + 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  int done_cnt = 0;
  int eng_low_cnt = 0;
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (rst && !eng_rst) eng_low_cnt <= eng_low_cnt + 1;
  end

  typedef struct {
    logic [7:0] msg;
    logic       err;
    logic [7:0] crc_out;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] msg, input logic is_err);
    exp_t e;
    e.msg = msg;
    e.err = is_err;
    if (!is_err) last_good = known_crc(msg);
    e.crc_out = last_good;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input logic [7:0] msg);
    frame_data = msg;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  // which: 0 = eng_active, 1 = eng_valid
  task automatic wait_level(input int which, input logic level, input string tag);
    int n;
    logic s;
    n = 0;
    s = (which == 0) ? eng_active : eng_valid;
    while (s !== level && n < 100) begin
      tick();
      n++;
      s = (which == 0) ? eng_active : eng_valid;
    end
    check(tag, s, level);
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_done"}, done, 1);
      check({tag, "_err"}, err, e.err);
      check({tag, "_crc_out"}, crc_out, e.crc_out);
      check({tag, "_eng_bits"}, stub_msg, e.msg);
      check({tag, "_eng_nbits"}, stub_bits, 8);
    end
  endtask

  task automatic run_frame(input logic [7:0] msg, input string tag);
    int d0;
    d0 = done_cnt;
    push_frame(msg, 1'b0);
    pulse_start(msg);
    wait_done({tag, "_wait"});
    check_frame(tag);
    tick();
    check({tag, "_done_low"}, done, 0);
    tick();
    check({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  initial begin
    int k;
    int low0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_eng_rst", eng_rst, 0);
    check("rst_eng_active", eng_active, 0);
    check("rst_eng_data", eng_data, 0);
    check("rst_crc_out", crc_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    tick();
    check("idle_eng_rst", eng_rst, 1);
    check("idle_busy", busy, 0);

    // Single frames
    eng_mode = 0;
    run_frame(8'h93, "f93");
    run_frame(8'h5D, "f5d");

    // Back-to-back with START held through DONE
    low0 = eng_low_cnt;
    push_frame(8'h93, 1'b0);
    frame_data = 8'h93;
    start = 1'b1;
    tick();
    check("b2b_busy", busy, 1);
    wait_done("b2b1_wait");
    check_frame("b2b1");
    frame_data = 8'h5D;
    push_frame(8'h5D, 1'b0);
    tick();
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_done", done, 0);
    tick();
    check("b2b_clear_eng_rst", eng_rst, 0);
    check("b2b_clear_busy", busy, 1);
    start = 1'b0;
    wait_done("b2b2_wait");
    check_frame("b2b2");
    check("b2b_eng_rst_low_cycles", eng_low_cnt - low0, 2);
    tick();

    // Timeout: engine never asserts Valid
    eng_mode = 1;
    push_frame(8'h11, 1'b1);
    pulse_start(8'h11);
    wait_level(0, 1'b1, "tmo_active_hi");
    wait_level(0, 1'b0, "tmo_active_lo");
    k = 0;
    while (done !== 1'b1 && k < TIMEOUT + 10) begin
      tick();
      k++;
    end
    check("tmo_latency", k, TIMEOUT);
    check_frame("tmo");
    tick();

    // Valid dropout after 3 result bits
    eng_mode = 2;
    push_frame(8'h22, 1'b1);
    pulse_start(8'h22);
    wait_level(1, 1'b1, "drop_valid_hi");
    wait_level(1, 1'b0, "drop_valid_lo");
    tick();
    check_frame("drop");
    tick();

    // Asynchronous reset in the middle of SHIFT
    eng_mode = 0;
    pulse_start(8'h93);
    wait_level(0, 1'b1, "mid_active_hi");
    repeat (4) tick();
    check("mid_active", eng_active, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_eng_rst", eng_rst, 0);
    check("mid_rst_eng_active", eng_active, 0);
    check("mid_rst_eng_data", eng_data, 0);
    check("mid_rst_crc_out", crc_out, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    last_good = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_frame(8'h93, "post_rst");

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
